// File: rtl/sliding_pattern_sequencer_if.sv
// rtl/sliding_pattern_sequencer_if.sv - raster mask output stream between sequencer and consumer
interface sliding_pattern_sequencer_if;
  logic        out_mask_bit;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;

  // Sequencer side: produces the raster stream, observes backpressure
  modport master (
    output out_mask_bit,
    output out_valid,
    input  out_ready,
    output out_x,
    output out_y,
    output out_sof,
    output out_eol,
    output out_eof
  );

  // Consumer side: accepts mask bits, drives backpressure
  modport slave (
    input  out_mask_bit,
    input  out_valid,
    output out_ready,
    input  out_x,
    input  out_y,
    input  out_sof,
    input  out_eol,
    input  out_eof
  );
endinterface

// File: rtl/sliding_pattern_sequencer.sv
// rtl/sliding_pattern_sequencer.sv - sequences a sliding_pattern ring into a framed raster mask stream
module sliding_pattern_sequencer #(
  parameter int IMG_W = 300,
  parameter int IMG_H = 300,
  parameter int FRM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [31:0]      cfg_pattern,
  input  logic             cfg_right_sliding,
  input  logic [FRM_W-1:0] cfg_frames,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sp_pattern,
  output logic             sp_right_sliding,
  output logic             sp_load_pattern,
  output logic             sp_clk_en,
  input  logic             sp_mask_bit,
  sliding_pattern_sequencer_if.master ob
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PRIME = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  state_t             state_q, state_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        y_q, y_d;
  logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]        pattern_q, pattern_d;
  logic               right_q, right_d;
  logic [FRM_W-1:0]   frames_q, frames_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               load_q, load_d;

  logic               xfer;
  logic               at_eol;
  logic               at_eof;
  logic               last_frame;
  logic               run_end;

  // Handshake and raster position decode from the registered counters
  always_comb begin
    xfer       = valid_q & ob.out_ready;
    at_eol     = (x_q == X_LAST);
    at_eof     = at_eol & (y_q == Y_LAST);
    // A zero frame count means continuous mode, so it never matches here
    last_frame = (frames_q != '0) && (frame_cnt_q == (frames_q - FRM_W'(1)));
    run_end    = clk_en & ~abort & (state_q == S_RUN) & xfer & at_eof & last_frame;
  end

  // Next-state, counter and config-latch computation
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    pattern_d   = pattern_q;
    right_d     = right_q;
    frames_d    = frames_q;

    if (clk_en) begin
      if (abort) begin
        // Abort wins over start and xfer; counters are left where they were
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              pattern_d   = cfg_pattern;
              right_d     = cfg_right_sliding;
              frames_d    = cfg_frames;
              x_d         = '0;
              y_d         = '0;
              frame_cnt_d = '0;
              state_d     = S_LOAD;
            end
          end
          S_LOAD:  state_d = S_PRIME;
          S_PRIME: state_d = S_RUN;
          S_RUN: begin
            if (xfer) begin
              if (at_eol) begin
                x_d = '0;
                if (at_eof) begin
                  // The ring is IMG_W wide, so it is back in phase at every row start
                  // and needs no reload between frames
                  y_d         = '0;
                  frame_cnt_d = frame_cnt_q + FRM_W'(1);
                  if (last_frame) begin
                    state_d = S_IDLE;
                  end
                end else begin
                  y_d = y_q + 16'd1;
                end
              end else begin
                x_d = x_q + 16'd1;
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Registered status outputs follow the next state, so they hold with clk_en low
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_RUN);
    load_d  = (state_d == S_LOAD);
  end

  // Single state register for the FSM, counters and latched configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      pattern_q   <= '0;
      right_q     <= 1'b0;
      frames_q    <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      pattern_q   <= pattern_d;
      right_q     <= right_d;
      frames_q    <= frames_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      load_q      <= load_d;
    end
  end

  // Ring shift enable: free-running in LOAD/PRIME, tied to consumer acceptance in RUN
  always_comb begin
    case (state_q)
      S_LOAD, S_PRIME: sp_clk_en = clk_en;
      S_RUN:           sp_clk_en = clk_en & ob.out_ready;
      default:         sp_clk_en = 1'b0;
    endcase
  end

  // Output stream and sliding_pattern drive
  always_comb begin
    busy             = busy_q;
    done             = run_end;
    sp_pattern       = pattern_q;
    sp_right_sliding = right_q;
    sp_load_pattern  = load_q;
    ob.out_mask_bit  = sp_mask_bit;
    ob.out_valid     = valid_q;
    ob.out_x         = x_q;
    ob.out_y         = y_q;
    ob.out_sof       = valid_q & (x_q == 16'd0) & (y_q == 16'd0);
    ob.out_eol       = valid_q & at_eol;
    ob.out_eof       = valid_q & at_eof;
  end

endmodule

// File: tb/tb_sliding_pattern_sequencer.sv
// tb/tb_sliding_pattern_sequencer.sv - directed bench for sliding_pattern_sequencer with a ring model
module tb_sliding_pattern_sequencer;
  localparam int W = 8;
  localparam int H = 2;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic [31:0]   cfg_pattern = '0;
  logic          cfg_right_sliding = 1'b0;
  logic [FW-1:0] cfg_frames = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [31:0]   sp_pattern;
  logic          sp_right_sliding, sp_load_pattern, sp_clk_en;
  logic          sp_mask_bit;

  int total = 0;
  int bad = 0;
  logic [7:0] pat = 8'hB5;

  sliding_pattern_sequencer_if ob();

  sliding_pattern_sequencer #(.IMG_W(W), .IMG_H(H), .FRM_W(FW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .cfg_pattern(cfg_pattern), .cfg_right_sliding(cfg_right_sliding), .cfg_frames(cfg_frames),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .sp_pattern(sp_pattern), .sp_right_sliding(sp_right_sliding),
    .sp_load_pattern(sp_load_pattern), .sp_clk_en(sp_clk_en),
    .sp_mask_bit(sp_mask_bit), .ob(ob)
  );

  always #5 clk = ~clk;

  // Behavioural sliding_pattern: W-wide ring, bit 0 emitted first for a left slide
  logic [W-1:0] ring;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ring <= '0;
      sp_mask_bit <= 1'b0;
    end else if (sp_clk_en) begin
      if (sp_load_pattern) begin
        ring <= sp_pattern[W-1:0];
      end else if (sp_right_sliding) begin
        sp_mask_bit <= ring[W-1];
        ring <= {ring[W-2:0], ring[W-1]};
      end else begin
        sp_mask_bit <= ring[0];
        ring <= {ring[0], ring[W-1:1]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] p, input logic [FW-1:0] frames);
    cfg_pattern = p;
    cfg_right_sliding = 1'b0;
    cfg_frames = frames;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("load_busy", busy, 1);
    chk("load_pulse", sp_load_pattern, 1);
    chk("load_spclk", sp_clk_en, 1);
    chk("load_valid", ob.out_valid, 0);
    step();
    @(negedge clk);
    chk("prime_load", sp_load_pattern, 0);
    chk("prime_spclk", sp_clk_en, 1);
    chk("prime_valid", ob.out_valid, 0);
    step();
  endtask

  // Walks xfers k0..n-1; mode 1 stalls with ready pattern 1,0,0
  task automatic run_xfers(input int k0, input int n, input int mode, input bit fin);
    int k = k0;
    int cyc = 0;
    int e;
    while (k < n && cyc < 4 * (n - k0) + 20) begin
      ob.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      e = k % (W * H);
      chk("valid", ob.out_valid, 1);
      chk("x", ob.out_x, e % W);
      chk("y", ob.out_y, e / W);
      if (ob.out_ready) begin
        chk("bit", ob.out_mask_bit, pat[k % W]);
        chk("sof", ob.out_sof, e == 0);
        chk("eol", ob.out_eol, (e % W) == W - 1);
        chk("eof", ob.out_eof, e == W * H - 1);
        chk("done", done, fin && (k == n - 1));
        chk("spclk_run", sp_clk_en, 1);
        k++;
      end else begin
        chk("spclk_stall", sp_clk_en, 0);
        chk("done_stall", done, 0);
      end
      step();
      cyc++;
    end
    chk("xfer_count", k, n);
    ob.out_ready = 1'b1;
  endtask

  initial begin
    ob.out_ready = 1'b1;
    #12;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ob.out_valid, 0);
    chk("rst_load", sp_load_pattern, 0);
    chk("rst_spclk", sp_clk_en, 0);
    chk("rst_done", done, 0);
    chk("rst_pat", sp_pattern, 0);
    rst = 1'b0;
    step();

    // 1: single frame, no backpressure
    do_start(32'h0000_00B5, 16'd1);
    chk("t1_pat", sp_pattern, 32'h0000_00B5);
    chk("t1_dir", sp_right_sliding, 0);
    run_xfers(0, 16, 0, 1'b1);
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_valid_end", ob.out_valid, 0);
    chk("t1_done_end", done, 0);
    step();

    // 2: stalling consumer
    do_start(32'h0000_00B5, 16'd1);
    run_xfers(0, 16, 1, 1'b1);
    @(negedge clk);
    chk("t2_busy_end", busy, 0);
    step();

    // 3: three frames; config changes while busy are ignored
    do_start(32'h0000_00B5, 16'd3);
    cfg_pattern = 32'h0;
    cfg_frames = 16'd1;
    run_xfers(0, 48, 0, 1'b1);
    @(negedge clk);
    chk("t3_busy_end", busy, 0);
    chk("t3_x_end", ob.out_x, 0);
    chk("t3_y_end", ob.out_y, 0);
    step();

    // 4: continuous run aborted during an xfer
    do_start(32'h0000_00B5, 16'd0);
    run_xfers(0, 20, 0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    chk("t4_done_abort", done, 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("t4_valid", ob.out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_x_held", ob.out_x, 4);
    chk("t4_y_held", ob.out_y, 0);
    step();
    do_start(32'h0000_00B5, 16'd1);
    run_xfers(0, 16, 0, 1'b1);

    // 5: start with abort in IDLE, then start during RUN
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_load", sp_load_pattern, 0);
    step();
    do_start(32'h0000_00B5, 16'd1);
    run_xfers(0, 5, 0, 1'b1 && 1'b0);
    ob.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("t5_run_busy", busy, 1);
    chk("t5_run_load", sp_load_pattern, 0);
    chk("t5_run_x", ob.out_x, 5);
    step();
    run_xfers(5, 16, 0, 1'b1);

    // 6: clock-enable freeze, then reset mid-run
    do_start(32'h0000_00B5, 16'd1);
    run_xfers(0, 10, 0, 1'b0);
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_spclk_frz", sp_clk_en, 0);
      chk("t6_x_frz", ob.out_x, 2);
      chk("t6_y_frz", ob.out_y, 1);
      step();
    end
    clk_en = 1'b1;
    run_xfers(10, 16, 0, 1'b1);
    do_start(32'h0000_00B5, 16'd1);
    run_xfers(0, 3, 0, 1'b0);
    rst = 1'b1;
    #2;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", ob.out_valid, 0);
    chk("t6_rst_spclk", sp_clk_en, 0);
    chk("t6_rst_x", ob.out_x, 0);
    chk("t6_rst_pat", sp_pattern, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
